// File: rtl/clast_fifo_n_if.sv
// Token handshake bundle for clast_fifo_n: upstream request/payload,
// downstream present/accept, and per-stage fire plus occupancy status.
interface clast_fifo_n_if #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
);
  localparam int NW = $clog2(DEPTH + 1);

  logic             i_drive;
  logic [WIDTH-1:0] i_data;
  logic             o_free;
  logic             o_driveNext;
  logic [WIDTH-1:0] o_data;
  logic             i_freeNext;
  logic [DEPTH-1:0] o_fire;
  logic [NW-1:0]    o_count;
  logic             o_overflow;

  modport master (
    output i_drive, i_data, i_freeNext,
    input  o_free, o_driveNext, o_data, o_fire, o_count, o_overflow
  );

  modport slave (
    input  i_drive, i_data, i_freeNext,
    output o_free, o_driveNext, o_data, o_fire, o_count, o_overflow
  );
endinterface

// File: rtl/clast_fifo_n.sv
// DEPTH-stage clocked token pipeline with a programmable exit delay,
// optional downstream acknowledge, per-stage fire pulses and overflow status.
module clast_fifo_n #(
  parameter int DEPTH    = 2,
  parameter int WIDTH    = 8,
  parameter int DELAY    = 2,
  parameter bit SELF_ACK = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  clast_fifo_n_if.slave  bus
);
  localparam int L  = DEPTH - 1;
  localparam int CW = $clog2(DELAY + 1);
  localparam int NW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] fire_q;
  logic [DEPTH-1:0] cap_s, leave_s;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             drive_next_s;
  logic [NW-1:0]    count_s;

  assign drive_next_s = v_q[L] && (cnt_q == {CW{1'b0}});

  // Capture/leave chain, resolved from the tail so a leaving stage can refill in the same cycle
  always_comb begin
    cap_s      = {DEPTH{1'b0}};
    leave_s    = {DEPTH{1'b0}};
    leave_s[L] = drive_next_s && (SELF_ACK || bus.i_freeNext);
    for (int k = L; k >= 1; k--) begin
      cap_s[k]     = v_q[k-1] && (!v_q[k] || leave_s[k]);
      leave_s[k-1] = cap_s[k];
    end
    cap_s[0] = bus.i_drive && !v_q[0];
  end

  // Next-state for valid bits, stage data, exit-delay counter and overflow flag
  always_comb begin
    v_d = (v_q & ~leave_s) | cap_s;
    d_d[0] = cap_s[0] ? bus.i_data : d_q[0];
    for (int k = 1; k < DEPTH; k++) begin
      if (cap_s[k]) begin
        d_d[k] = d_q[k-1];
      end else begin
        d_d[k] = d_q[k];
      end
    end
    if (cap_s[L]) begin
      cnt_d = CW'(DELAY);
    end else if (v_q[L] && (cnt_q != {CW{1'b0}})) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
    ovf_d = ovf_q | (bus.i_drive & v_q[0]);
  end

  // Occupancy is the population count of the valid bits
  always_comb begin
    count_s = {NW{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      count_s = count_s + NW'(v_q[k]);
    end
  end

  // State registers; reset discards any tokens in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q    <= {DEPTH{1'b0}};
      fire_q <= {DEPTH{1'b0}};
      cnt_q  <= {CW{1'b0}};
      ovf_q  <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= {WIDTH{1'b0}};
      end
    end else begin
      v_q    <= v_d;
      fire_q <= cap_s;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      for (int k = 0; k < DEPTH; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

  assign bus.o_free      = !v_q[0];
  assign bus.o_driveNext = drive_next_s;
  assign bus.o_data      = drive_next_s ? d_q[L] : {WIDTH{1'b0}};
  assign bus.o_fire      = fire_q;
  assign bus.o_count     = count_s;
  assign bus.o_overflow  = ovf_q;
endmodule
